// File: rtl/r5p_ls_pkg.sv
// r5p_ls_pkg: shared types and constants for the R5P load/store memory responder.
//   ls_mem_state_t : handshake FSM states (IDLE, WAIT, ACK)
//   LS_LFSR_POLY   : Galois feedback mask for x^16+x^14+x^13+x^11+1
//   LS_LFSR_SEED   : LFSR value loaded at reset
package r5p_ls_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      ACK  = 2'd2
   } ls_mem_state_t;

   localparam logic [15:0] LS_LFSR_POLY = 16'hB400;
   localparam logic [15:0] LS_LFSR_SEED = 16'hACE1;

endpackage

// File: rtl/r5p_ls_mem_ram.sv
// r5p_ls_mem_ram: DEPTH x DW single-port array, byte-enable write, registered read.
//   clk, rst : clock, async active-high reset (clears the read register only)
//   i_we     : write strobe, bytes selected by i_ben written from i_wdt at i_idx
//   i_re     : read strobe, o_rdt loads mem[i_idx], or zero when i_zero is set
//   o_rdt    : registered read data, held between read strobes
module r5p_ls_mem_ram #(
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 1024
)(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_we,
   input  logic                     i_re,
   input  logic                     i_zero,
   input  logic [$clog2(DEPTH)-1:0] i_idx,
   input  logic [DW/8-1:0]          i_ben,
   input  logic [DW-1:0]            i_wdt,
   output logic [DW-1:0]            o_rdt
);

   localparam int unsigned BW = DW / 8;

   logic [DW-1:0] r_mem [DEPTH];

   // Storage has no reset so it maps onto plain SRAM macros or inferred arrays.
   always_ff @(posedge clk) begin
      if (i_we) begin
         for (int unsigned b = 0; b < BW; b++) begin
            if (i_ben[b]) r_mem[i_idx][b*8 +: 8] <= i_wdt[b*8 +: 8];
         end
      end
   end

   // Read register; an out-of-range read returns zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       o_rdt <= '0;
      else if (i_re) o_rdt <= i_zero ? '0 : r_mem[i_idx];
   end

endmodule

// File: rtl/r5p_ls_mem.sv
// r5p_ls_mem: responder end of the R5P load/store bus, tightly-coupled data memory.
//   clk, rst : clock, async active-high reset
//   ls_vld   : request valid         ls_wen : 1=store, 0=load
//   ls_adr   : byte address          ls_ben : byte enables    ls_wdt : store data
//   ls_rdt   : registered load data  ls_rdy : request accepted this cycle
//   ls_err   : one-cycle pulse after an accepted out-of-range request
// Optional build macro R5P_LS_MEM_STALL_EN adds LFSR-driven random backpressure.
module r5p_ls_mem
   import r5p_ls_pkg::*;
#(
   parameter int unsigned    AW   = 32,
   parameter int unsigned    DW   = 32,
   parameter int unsigned    BW   = DW/8,
   parameter int unsigned    SIZE = 4096,
   parameter logic [AW-1:0]  BASE = '0,
   parameter int unsigned    WS   = 0
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          ls_vld,
   input  logic          ls_wen,
   input  logic [AW-1:0] ls_adr,
   input  logic [BW-1:0] ls_ben,
   input  logic [DW-1:0] ls_wdt,
   output logic [DW-1:0] ls_rdt,
   output logic          ls_rdy,
   output logic          ls_err
);

   localparam int unsigned LW = $clog2(BW);
   localparam int unsigned IW = $clog2(SIZE) - LW;
   localparam int unsigned CW = 4;

   ls_mem_state_t r_state, w_state_nxt;
   logic [CW-1:0] r_cnt, w_cnt_nxt;
   logic          r_err;
   logic          w_rdy;
   logic          w_stall;
   logic          w_xfer;
   logic [AW-1:0] w_off;
   logic          w_in_range;
   logic [IW-1:0] w_idx;

   // Range decode: offset wraps in AW bits so addresses below BASE land out of range.
   assign w_off      = ls_adr - BASE;
   assign w_in_range = (w_off < AW'(SIZE));
   assign w_idx      = IW'(w_off >> LW);

`ifdef R5P_LS_MEM_STALL_EN
   logic [15:0] r_lfsr;

   // Galois LFSR, one step per cycle; bit 0 requests a stall.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_lfsr <= LS_LFSR_SEED;
      else     r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LS_LFSR_POLY : 16'h0000);
   end
   assign w_stall = r_lfsr[0];
`else
   assign w_stall = 1'b0;
`endif

   // State register and wait counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state and ready; a dropped ls_vld in WAIT/ACK abandons the request.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rdy       = 1'b0;
      if (WS == 0) begin
         w_rdy = ls_vld & ~w_stall;
      end else begin
         case (r_state)
            IDLE: begin
               if (ls_vld) begin
                  w_state_nxt = WAIT;
                  w_cnt_nxt   = CW'(WS - 1);
               end
            end
            WAIT: begin
               if (!ls_vld)         w_state_nxt = IDLE;
               else if (r_cnt == 0) w_state_nxt = ACK;
               else                 w_cnt_nxt   = r_cnt - 1'b1;
            end
            ACK: begin
               if (!ls_vld) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_rdy = ~w_stall;
                  if (!w_stall) w_state_nxt = IDLE;
               end
            end
            default: w_state_nxt = IDLE;
         endcase
      end
   end

   assign ls_rdy = w_rdy & ~rst;
   assign w_xfer = ls_vld & ls_rdy;

   // Error pulse for the cycle after an accepted out-of-range request.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_err <= 1'b0;
      else     r_err <= w_xfer & ~w_in_range;
   end
   assign ls_err = r_err;

   r5p_ls_mem_ram #(
      .DW    (DW),
      .DEPTH (SIZE/BW)
   ) u_ram (
      .clk    (clk),
      .rst    (rst),
      .i_we   (w_xfer & ls_wen & w_in_range),
      .i_re   (w_xfer & ~ls_wen),
      .i_zero (~w_in_range),
      .i_idx  (w_idx),
      .i_ben  (ls_ben),
      .i_wdt  (ls_wdt),
      .o_rdt  (ls_rdt)
   );

endmodule
